// File: rtl/hdr_stream_fifo.sv
// hdr_stream_fifo: frame-aware buffer behind the HDR wrapper. It absorbs a non-stallable Avalon-ST
// input and presents a back-pressurable source. On overflow it truncates the frame with an err-flagged EOP.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// WAIT_SOP | discard input until a frame start can be stored
// PASS     | storing the current frame
// TERM     | frame overflowed; waiting for a free slot to write terminator
module hdr_stream_fifo #(
   parameter int DATA_WIDTH = 16,
   parameter int ADDR_W     = 10
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  asi_snk_valid_i,
   input  logic [DATA_WIDTH-1:0] asi_snk_data_i,
   input  logic                  asi_snk_startofpacket_i,
   input  logic                  asi_snk_endofpacket_i,
   output logic                  aso_src_valid_o,
   input  logic                  aso_src_ready_i,
   output logic [DATA_WIDTH-1:0] aso_src_data_o,
   output logic                  aso_src_startofpacket_o,
   output logic                  aso_src_endofpacket_o,
   output logic                  aso_src_error_o,
   output logic [ADDR_W:0]       fill_level_o,
   output logic [15:0]           frame_cnt_o,
   output logic [15:0]           drop_cnt_o
);

   localparam int DEPTH = 1 << ADDR_W;
   localparam int EW    = DATA_WIDTH + 3;
   localparam logic [ADDR_W:0] CNT_FULL = {1'b1, {ADDR_W{1'b0}}};
   localparam logic [ADDR_W:0] CNT_ONE  = {{ADDR_W{1'b0}}, 1'b1};

   typedef enum logic [1:0] {WAIT_SOP = 2'd0, PASS = 2'd1, TERM = 2'd2} wr_state_t;

   wr_state_t             state, state_nxt;
   logic [1:0]            rst_sync;
   logic                  run;
   logic [EW-1:0]         mem [DEPTH];
   logic [EW-1:0]         rd_data, wr_word;
   logic [ADDR_W-1:0]     wr_ptr, rd_ptr, rd_ptr_nxt;
   logic [ADDR_W:0]       count;
   logic                  full, head_ok, load, wr_en, wr_go, wr_d, frame_inc, drop_inc;
   logic                  out_valid, out_sop, out_eop, out_err;
   logic [DATA_WIDTH-1:0] out_data;
   logic [15:0]           frame_cnt, drop_cnt;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) rst_sync <= 2'b00;
      else          rst_sync <= {rst_sync[0], 1'b1};
   end

   assign run        = rst_sync[1];
   assign full       = (count == CNT_FULL);
   assign wr_go      = wr_en & run;
   // RAM read is registered on rd_ptr_nxt, so an entry written on the last edge is not in rd_data yet.
   assign head_ok    = (count != '0) && !((count == CNT_ONE) && wr_d);
   assign load       = run & head_ok & (~out_valid | aso_src_ready_i);
   assign rd_ptr_nxt = load ? rd_ptr + 1'b1 : rd_ptr;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)  state <= WAIT_SOP;
      else if (run)  state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         WAIT_SOP: if (asi_snk_valid_i && asi_snk_startofpacket_i && !full && !asi_snk_endofpacket_i)
                      state_nxt = PASS;
         PASS:     if (asi_snk_valid_i) begin
                      if (full)                       state_nxt = TERM;
                      else if (asi_snk_endofpacket_i) state_nxt = WAIT_SOP;
                   end
         TERM:     if (!full) state_nxt = WAIT_SOP;
         default:  state_nxt = WAIT_SOP;
      endcase
   end

   always_comb begin
      wr_en     = 1'b0;
      wr_word   = {asi_snk_data_i, asi_snk_startofpacket_i, asi_snk_endofpacket_i, 1'b0};
      frame_inc = 1'b0;
      drop_inc  = 1'b0;
      case (state)
         WAIT_SOP: if (asi_snk_valid_i && asi_snk_startofpacket_i && !full) begin
                      wr_en     = 1'b1;
                      frame_inc = asi_snk_endofpacket_i;
                   end
         PASS:     if (asi_snk_valid_i) begin
                      if (full) drop_inc = 1'b1;
                      else begin
                         wr_en     = 1'b1;
                         frame_inc = asi_snk_endofpacket_i;
                      end
                   end
         TERM:     if (!full) begin
                      wr_en   = 1'b1;
                      wr_word = {{DATA_WIDTH{1'b0}}, 3'b011};
                   end
         default:  ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (wr_go) mem[wr_ptr] <= wr_word;
      rd_data <= mem[rd_ptr_nxt];
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         wr_d   <= 1'b0;
      end else if (run) begin
         if (wr_go) wr_ptr <= wr_ptr + 1'b1;
         rd_ptr <= rd_ptr_nxt;
         wr_d   <= wr_go;
         case ({wr_go, load})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_sop   <= 1'b0;
         out_eop   <= 1'b0;
         out_err   <= 1'b0;
      end else if (load) begin
         out_valid <= 1'b1;
         {out_data, out_sop, out_eop, out_err} <= rd_data;
      end else if (aso_src_ready_i) begin
         out_valid <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         frame_cnt <= '0;
         drop_cnt  <= '0;
      end else if (run) begin
         if (frame_inc) frame_cnt <= frame_cnt + 16'd1;
         if (drop_inc)  drop_cnt  <= drop_cnt + 16'd1;
      end
   end

   assign aso_src_valid_o         = out_valid;
   assign aso_src_data_o          = out_data;
   assign aso_src_startofpacket_o = out_sop;
   assign aso_src_endofpacket_o   = out_eop;
   assign aso_src_error_o         = out_err;
   assign fill_level_o            = count;
   assign frame_cnt_o             = frame_cnt;
   assign drop_cnt_o              = drop_cnt;

endmodule

// File: tb/tb_hdr_stream_fifo.sv
// Scoreboard bench for hdr_stream_fifo: a deep instance for streaming/reset cases and an
// ADDR_W=4 instance for overflow and terminator handling.
module tb_hdr_stream_fifo;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   always #5 clk = ~clk;

   logic        a_valid, a_sop, a_eop, a_ready;
   logic [15:0] a_data;
   logic        a_ovalid, a_osop, a_oeop, a_oerr;
   logic [15:0] a_odata, a_frames, a_drops;
   logic [10:0] a_fill;

   logic        b_valid, b_sop, b_eop, b_ready;
   logic [15:0] b_data;
   logic        b_ovalid, b_osop, b_oeop, b_oerr;
   logic [15:0] b_odata, b_frames, b_drops;
   logic [4:0]  b_fill;

   hdr_stream_fifo #(.DATA_WIDTH(16), .ADDR_W(10)) u_dut (
      .clk(clk), .reset_n(reset_n),
      .asi_snk_valid_i(a_valid), .asi_snk_data_i(a_data),
      .asi_snk_startofpacket_i(a_sop), .asi_snk_endofpacket_i(a_eop),
      .aso_src_valid_o(a_ovalid), .aso_src_ready_i(a_ready), .aso_src_data_o(a_odata),
      .aso_src_startofpacket_o(a_osop), .aso_src_endofpacket_o(a_oeop), .aso_src_error_o(a_oerr),
      .fill_level_o(a_fill), .frame_cnt_o(a_frames), .drop_cnt_o(a_drops)
   );

   hdr_stream_fifo #(.DATA_WIDTH(16), .ADDR_W(4)) u_small (
      .clk(clk), .reset_n(reset_n),
      .asi_snk_valid_i(b_valid), .asi_snk_data_i(b_data),
      .asi_snk_startofpacket_i(b_sop), .asi_snk_endofpacket_i(b_eop),
      .aso_src_valid_o(b_ovalid), .aso_src_ready_i(b_ready), .aso_src_data_o(b_odata),
      .aso_src_startofpacket_o(b_osop), .aso_src_endofpacket_o(b_oeop), .aso_src_error_o(b_oerr),
      .fill_level_o(b_fill), .frame_cnt_o(b_frames), .drop_cnt_o(b_drops)
   );

   int          n_cmp = 0;
   int          n_fail = 0;
   logic [18:0] qa[$];
   logic [18:0] qb[$];
   logic [18:0] a_word, b_word, a_prev, b_prev;
   logic        a_stall, b_stall;
   bit          rr_done;

   assign a_word = {a_odata, a_osop, a_oeop, a_oerr};
   assign b_word = {b_odata, b_osop, b_oeop, b_oerr};

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h required 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (!reset_n) begin
         a_stall <= 1'b0;
      end else begin
         if (a_stall) begin
            chk("a_hold_valid", a_ovalid, 1);
            chk("a_hold_word", a_word, a_prev);
         end
         if (a_ovalid && a_ready) begin
            if (qa.size() == 0) begin
               n_cmp++; n_fail++;
               $display("FAIL a_unexpected: got beat 0x%0h required none at %0t", a_word, $time);
            end else chk("a_beat", a_word, qa.pop_front());
         end
         a_stall <= a_ovalid && !a_ready;
         a_prev  <= a_word;
      end
   end

   always @(negedge clk) begin
      if (!reset_n) begin
         b_stall <= 1'b0;
      end else begin
         if (b_stall) begin
            chk("b_hold_valid", b_ovalid, 1);
            chk("b_hold_word", b_word, b_prev);
         end
         if (b_ovalid && b_ready) begin
            if (qb.size() == 0) begin
               n_cmp++; n_fail++;
               $display("FAIL b_unexpected: got beat 0x%0h required none at %0t", b_word, $time);
            end else chk("b_beat", b_word, qb.pop_front());
         end
         b_stall <= b_ovalid && !b_ready;
         b_prev  <= b_word;
      end
   end

   task automatic beat_a(input logic [15:0] d, input logic s, input logic e, input logic push);
      a_valid = 1'b1; a_data = d; a_sop = s; a_eop = e;
      if (push) qa.push_back({d, s, e, 1'b0});
      @(posedge clk); #1;
      a_valid = 1'b0; a_sop = 1'b0; a_eop = 1'b0;
   endtask

   task automatic beat_b(input logic [15:0] d, input logic s, input logic e, input logic push);
      b_valid = 1'b1; b_data = d; b_sop = s; b_eop = e;
      if (push) qb.push_back({d, s, e, 1'b0});
      @(posedge clk); #1;
      b_valid = 1'b0; b_sop = 1'b0; b_eop = 1'b0;
   endtask

   task automatic drain_a(input int budget);
      int n = 0;
      while (qa.size() != 0 && n < budget) begin @(posedge clk); n++; end
      repeat (3) @(posedge clk);
      #1;
      n_cmp++;
      if (qa.size() != 0) begin
         n_fail++;
         $display("FAIL a_drain: %0d beats still expected, required 0", qa.size());
      end
   endtask

   task automatic drain_b(input int budget);
      int n = 0;
      while (qb.size() != 0 && n < budget) begin @(posedge clk); n++; end
      repeat (3) @(posedge clk);
      #1;
      n_cmp++;
      if (qb.size() != 0) begin
         n_fail++;
         $display("FAIL b_drain: %0d beats still expected, required 0", qb.size());
      end
   endtask

   task automatic apply_reset();
      reset_n = 1'b0;
      qa.delete();
      qb.delete();
      repeat (2) @(posedge clk);
      #1 reset_n = 1'b1;
      repeat (4) @(posedge clk);
      #1;
   endtask

   initial begin
      a_valid = 0; a_sop = 0; a_eop = 0; a_data = '0; a_ready = 1'b1;
      b_valid = 0; b_sop = 0; b_eop = 0; b_data = '0; b_ready = 1'b0;
      apply_reset();
      chk("a_rst_out", {a_ovalid, a_word}, 0);
      chk("a_rst_fill", a_fill, 0);
      chk("a_rst_cnts", {a_frames, a_drops}, 0);
      chk("b_rst_out", {b_ovalid, b_word}, 0);

      // 16-beat frame, ready high, first-beat latency
      for (int i = 0; i < 16; i++) begin
         beat_a(16'(i), i == 0, i == 15, 1'b1);
         if (i == 1) chk("lat_k1_valid", a_ovalid, 0);
         if (i == 2) chk("lat_k2_valid", a_ovalid, 1);
      end
      drain_a(100);
      chk("t1_frames", a_frames, 1);
      chk("t1_drops", a_drops, 0);

      // stray beats before any SOP are discarded
      apply_reset();
      for (int i = 0; i < 5; i++) beat_a(16'(16'h0100 + i), 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) beat_a(16'(16'h0200 + i), i == 0, i == 3, 1'b1);
      drain_a(100);
      chk("t2_frames", a_frames, 1);
      chk("t2_fill", a_fill, 0);

      // overflow on the 16-deep instance: 16 RAM entries plus the output register hold beats 0..16
      b_ready = 1'b0;
      for (int i = 0; i < 20; i++) beat_b(16'(16'h0300 + i), i == 0, i == 19, i < 17);
      chk("t3_fill", b_fill, 16);
      chk("t3_drops", b_drops, 1);
      chk("t3_frames", b_frames, 0);
      b_ready = 1'b1;
      @(posedge clk); #1;
      // first slot frees on the previous edge; this SOP meets the terminator write
      qb.push_back({16'h0000, 1'b0, 1'b1, 1'b1});
      for (int i = 0; i < 6; i++) beat_b(16'(16'h0400 + i), i == 0, i == 5, 1'b0);
      for (int i = 0; i < 5; i++) beat_b(16'(16'h0500 + i), i == 0, i == 4, 1'b1);
      drain_b(200);
      chk("t4_frames", b_frames, 1);
      chk("t4_drops", b_drops, 1);
      chk("t4_fill", b_fill, 0);

      // three back-to-back 100-beat frames with random ready
      apply_reset();
      rr_done = 1'b0;
      fork
         begin
            for (int f = 0; f < 3; f++)
               for (int i = 0; i < 100; i++)
                  beat_a(16'(16'h1000 * (f + 1) + i * 3), i == 0, i == 99, 1'b1);
            rr_done = 1'b1;
         end
         begin
            while (!rr_done) begin
               a_ready = 1'($urandom_range(0, 1));
               @(posedge clk); #1;
            end
         end
      join
      a_ready = 1'b1;
      drain_a(2000);
      chk("t5_frames", a_frames, 3);
      chk("t5_drops", a_drops, 0);

      // reset mid-frame with 8 entries stored
      a_ready = 1'b0;
      for (int i = 0; i < 9; i++) beat_a(16'(16'h0700 + i), i == 0, 1'b0, 1'b0);
      chk("t6_fill_pre", a_fill, 8);
      reset_n = 1'b0;
      #1;
      chk("t6_rst_out", {a_ovalid, a_word}, 0);
      chk("t6_rst_fill", a_fill, 0);
      chk("t6_rst_cnts", {a_frames, a_drops}, 0);
      apply_reset();
      a_ready = 1'b1;
      for (int i = 9; i < 16; i++) beat_a(16'(16'h0700 + i), 1'b0, i == 15, 1'b0);
      for (int i = 0; i < 3; i++) beat_a(16'(16'h0800 + i), i == 0, i == 2, 1'b1);
      drain_a(100);
      chk("t6_frames", a_frames, 1);
      chk("t6_fill", a_fill, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
